// File: rtl/cs_window_ctrl.sv
// Sliding-window controller: fills a WIN-slot sample buffer, launches one datapath evaluation per window, holds the result.
// One dp_start per full window or slide; input and new evaluations are stalled while Y waits for y_ready.
module cs_window_ctrl #(
   parameter int WIN = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       flush,
   output logic       buf_we,
   output logic [3:0] buf_addr,
   output logic [7:0] buf_wdata,
   output logic       dp_start,
   input  logic       dp_done,
   input  logic [9:0] dp_result,
   output logic [9:0] Y,
   output logic       y_valid,
   input  logic       y_ready,
   output logic [3:0] fill_cnt
);

   localparam logic [2:0] S_FILL  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_SLIDE = 3'd4;

   localparam logic [3:0] LP_WIN  = 4'(WIN);
   localparam logic [3:0] LP_LAST = 4'(WIN - 1);

   logic [2:0] r_state;
   logic [3:0] r_wr_ptr;
   logic [3:0] r_fill_cnt;
   logic [9:0] r_y;
   logic       r_y_valid;

   logic       w_in_ready;
   logic       w_accept;
   logic [3:0] w_ptr_next;
   logic [3:0] w_cnt_next;

   // Flush blocks acceptance so the flushed cycle never writes the buffer.
   assign w_in_ready = !reset && !flush && ((r_state == S_FILL) || (r_state == S_SLIDE));
   assign w_accept   = in_valid && w_in_ready;
   assign w_ptr_next = (r_wr_ptr == LP_LAST) ? 4'd0 : r_wr_ptr + 4'd1;
   assign w_cnt_next = (r_fill_cnt == LP_WIN) ? LP_WIN : r_fill_cnt + 4'd1;

   assign in_ready  = w_in_ready;
   assign buf_we    = w_accept;
   assign buf_addr  = r_wr_ptr;
   assign buf_wdata = in_data;
   assign dp_start  = !reset && (r_state == S_START);
   assign Y         = r_y;
   assign y_valid   = r_y_valid;
   assign fill_cnt  = r_fill_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_FILL;
         r_wr_ptr   <= 4'd0;
         r_fill_cnt <= 4'd0;
         r_y        <= 10'd0;
         r_y_valid  <= 1'b0;
      end else if (flush) begin
         // Y is deliberately kept; only its valid flag is dropped.
         r_state    <= S_FILL;
         r_wr_ptr   <= 4'd0;
         r_fill_cnt <= 4'd0;
         r_y_valid  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr   <= w_ptr_next;
            r_fill_cnt <= w_cnt_next;
         end
         case (r_state)
            S_FILL: begin
               if (w_accept && (w_cnt_next == LP_WIN)) begin
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (dp_done) begin
                  r_y       <= dp_result;
                  r_y_valid <= 1'b1;
                  r_state   <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (r_y_valid && y_ready) begin
                  r_y_valid <= 1'b0;
                  r_state   <= S_SLIDE;
               end
            end
            S_SLIDE: begin
               if (w_accept) begin
                  r_state <= S_START;
               end
            end
            default: begin
               r_state <= S_FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cs_window_ctrl.sv
// Directed bench for cs_window_ctrl: fill, result handshake, slide/wrap, backpressure, flush and reset.
module tb_cs_window_ctrl;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       flush;
   logic       buf_we;
   logic [3:0] buf_addr;
   logic [7:0] buf_wdata;
   logic       dp_start;
   logic       dp_done;
   logic [9:0] dp_result;
   logic [9:0] Y;
   logic       y_valid;
   logic       y_ready;
   logic [3:0] fill_cnt;

   int checks = 0;
   int errors = 0;

   cs_window_ctrl #(.WIN(9)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .flush     (flush),
      .buf_we    (buf_we),
      .buf_addr  (buf_addr),
      .buf_wdata (buf_wdata),
      .dp_start  (dp_start),
      .dp_done   (dp_done),
      .dp_result (dp_result),
      .Y         (Y),
      .y_valid   (y_valid),
      .y_ready   (y_ready),
      .fill_cnt  (fill_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are read 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      flush     = 1'b0;
      dp_done   = 1'b0;
      dp_result = 10'd0;
      y_ready   = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 16'(in_ready), 16'd0);
      check("rst_buf_we",   16'(buf_we),   16'd0);
      check("rst_dp_start", 16'(dp_start), 16'd0);
      check("rst_y_valid",  16'(y_valid),  16'd0);
      check("rst_Y",        16'(Y),        16'd0);
      check("rst_fill_cnt", 16'(fill_cnt), 16'd0);

      // Fill the window with 0x10..0x18.
      reset = 1'b0;
      for (int i = 0; i < 9; i++) begin
         in_data = 8'(8'h10 + i);
         #1;
         check("fill_in_ready", 16'(in_ready),  16'd1);
         check("fill_buf_we",   16'(buf_we),    16'd1);
         check("fill_addr",     16'(buf_addr),  16'(i));
         check("fill_wdata",    16'(buf_wdata), 16'(8'h10 + i));
         check("fill_cnt",      16'(fill_cnt),  16'(i));
         check("fill_no_start", 16'(dp_start),  16'd0);
         tick();
      end
      check("full_cnt",      16'(fill_cnt), 16'd9);
      check("start_pulse",   16'(dp_start), 16'd1);
      check("start_ready",   16'(in_ready), 16'd0);
      check("start_buf_we",  16'(buf_we),   16'd0);
      tick();
      check("wait1_start",   16'(dp_start), 16'd0);
      check("wait1_ready",   16'(in_ready), 16'd0);
      check("wait1_yvalid",  16'(y_valid),  16'd0);
      tick();
      dp_done   = 1'b1;
      dp_result = 10'h2A3;
      y_ready   = 1'b1;
      #1;
      check("wait2_yvalid",  16'(y_valid),  16'd0);
      tick();
      dp_done = 1'b0;
      check("hold_yvalid",   16'(y_valid),  16'd1);
      check("hold_Y",        16'(Y),        16'h2A3);
      check("hold_ready",    16'(in_ready), 16'd0);
      tick();
      check("slide_yvalid",  16'(y_valid),  16'd0);
      check("slide_ready",   16'(in_ready), 16'd1);
      check("slide_Y_kept",  16'(Y),        16'h2A3);

      // Three slides that wrap the write pointer; dp_done during START must be ignored.
      for (int j = 0; j < 3; j++) begin
         in_data = 8'(8'h20 + j);
         #1;
         check("slide_addr",   16'(buf_addr), 16'(j));
         check("slide_we",     16'(buf_we),   16'd1);
         tick();
         check("slide_start",  16'(dp_start), 16'd1);
         check("slide_cnt",    16'(fill_cnt), 16'd9);
         dp_done   = 1'b1;
         dp_result = 10'h111;
         tick();
         check("start_done_ignored", 16'(y_valid), 16'd0);
         check("slide_wait_we",      16'(buf_we),  16'd0);
         dp_result = 10'(10'h100 + j);
         tick();
         dp_done = 1'b0;
         check("slide_Y",      16'(Y),        16'(10'h100 + j));
         check("slide_hold_v", 16'(y_valid),  16'd1);
         tick();
      end

      // Backpressure on Y for five cycles.
      in_data = 8'h30;
      #1;
      check("bp_addr", 16'(buf_addr), 16'd3);
      tick();
      tick();
      y_ready   = 1'b0;
      dp_done   = 1'b1;
      dp_result = 10'h155;
      tick();
      dp_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("bp_yvalid", 16'(y_valid),  16'd1);
         check("bp_Y",      16'(Y),        16'h155);
         check("bp_ready",  16'(in_ready), 16'd0);
         tick();
      end
      y_ready = 1'b1;
      #1;
      check("bp_release_v", 16'(y_valid), 16'd1);
      tick();
      check("bp_drop_v",    16'(y_valid),  16'd0);
      check("bp_slide_rdy", 16'(in_ready), 16'd1);
      check("bp_next_addr", 16'(buf_addr), 16'd4);

      // Flush while WAIT, then a late dp_done.
      in_data = 8'h31;
      tick();
      tick();
      flush = 1'b1;
      #1;
      check("flush_ready", 16'(in_ready), 16'd0);
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      dp_done   = 1'b1;
      dp_result = 10'h3FF;
      #1;
      check("flush_cnt",   16'(fill_cnt), 16'd0);
      check("flush_addr",  16'(buf_addr), 16'd0);
      check("flush_fill",  16'(in_ready), 16'd1);
      tick();
      dp_done = 1'b0;
      check("late_done_v", 16'(y_valid),  16'd0);
      check("late_Y_kept", 16'(Y),        16'h155);

      // A sample offered together with flush is dropped.
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      #1;
      check("flush_in_ready", 16'(in_ready), 16'd0);
      check("flush_buf_we",   16'(buf_we),   16'd0);
      tick();
      flush = 1'b0;
      check("flush_cnt2", 16'(fill_cnt), 16'd0);

      for (int i = 0; i < 9; i++) begin
         in_data = 8'(8'h40 + i);
         #1;
         check("refill_addr",     16'(buf_addr), 16'(i));
         check("refill_no_start", 16'(dp_start), 16'd0);
         tick();
      end
      check("refill_start", 16'(dp_start), 16'd1);
      tick();
      dp_done   = 1'b1;
      dp_result = 10'h0AB;
      y_ready   = 1'b0;
      tick();
      dp_done = 1'b0;
      check("pre_rst_v", 16'(y_valid), 16'd1);
      check("pre_rst_Y", 16'(Y),       16'h0AB);

      // Reset from HOLD, then a spurious dp_done in FILL.
      reset = 1'b1;
      #1;
      check("rst_hold_ready", 16'(in_ready), 16'd0);
      check("rst_hold_we",    16'(buf_we),   16'd0);
      tick();
      check("rst_hold_v",   16'(y_valid),  16'd0);
      check("rst_hold_Y",   16'(Y),        16'd0);
      check("rst_hold_cnt", 16'(fill_cnt), 16'd0);
      reset     = 1'b0;
      in_valid  = 1'b0;
      dp_done   = 1'b1;
      dp_result = 10'h123;
      tick();
      dp_done = 1'b0;
      check("spurious_done_v", 16'(y_valid), 16'd0);
      check("spurious_Y",      16'(Y),       16'd0);
      check("post_rst_start",  16'(dp_start), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cs_window_ctrl.md
CS_WINDOW_CTRL -- requirements
Module: cs_window_ctrl

Interface
REQ-001 Parameter WIN, default 9: samples per window; the legal range is 2..15.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port in_valid, input, 1 bit: the source offers a sample.
REQ-005 Port in_data, input, 8 bits: the offered sample X.
REQ-006 Port in_ready, output, 1 bit: the controller accepts in_data this cycle.
REQ-007 Port flush, input, 1 bit: discard the window contents and restart filling.
REQ-008 Port buf_we, output, 1 bit: write strobe to the window buffer.
REQ-009 Port buf_addr, output, 4 bits: window buffer slot, 0..WIN-1.
REQ-010 Port buf_wdata, output, 8 bits: data written to the window buffer.
REQ-011 Port dp_start, output, 1 bit: one-cycle pulse that starts one datapath evaluation.
REQ-012 Port dp_done, input, 1 bit: the datapath result is valid this cycle.
REQ-013 Port dp_result, input, 10 bits: the datapath result.
REQ-014 Port Y, output, 10 bits: the registered result.
REQ-015 Port y_valid, output, 1 bit: Y holds an unconsumed result.
REQ-016 Port y_ready, input, 1 bit: the sink accepts Y.
REQ-017 Port fill_cnt, output, 4 bits: number of valid samples in the window, 0..WIN.

Function
REQ-018 The FSM SHALL have the states FILL, START, WAIT, HOLD and SLIDE, and SHALL enter FILL on reset.
REQ-019 in_ready SHALL be 1 only in FILL or SLIDE, and SHALL be 0 while reset is high.
REQ-020 buf_we SHALL equal in_valid AND in_ready, combinationally; buf_wdata SHALL equal in_data; buf_addr SHALL equal wr_ptr.
REQ-021 On each accept, wr_ptr SHALL increment modulo WIN (WIN-1 -> 0), so a SLIDE write overwrites the oldest sample.
REQ-022 On each accept, fill_cnt SHALL increment and saturate at WIN.
REQ-023 FILL -> START SHALL occur on the accept that makes fill_cnt reach WIN; otherwise the FSM SHALL remain in FILL.
REQ-024 SLIDE -> START SHALL occur on any accept; with no accept, the FSM SHALL remain in SLIDE.
REQ-025 START SHALL last exactly 1 cycle with dp_start=1, then the FSM SHALL go to WAIT; dp_start SHALL be 0 in every other state.
REQ-026 In WAIT, on dp_done=1: Y<=dp_result, y_valid<=1, and the FSM SHALL go to HOLD; otherwise it SHALL remain in WAIT.
REQ-027 dp_done SHALL be ignored in every state except WAIT, including when it coincides with the START cycle.
REQ-028 In HOLD, Y and y_valid SHALL stay stable until y_valid AND y_ready; on that cycle the controller SHALL set y_valid<=0 and go to SLIDE.
REQ-029 y_ready while y_valid=0 SHALL have no effect.
REQ-030 Latency: for a 9th accept at edge t and dp_done in cycle t+k (k>=2), dp_start SHALL be high in cycle t+1 and y_valid SHALL rise at edge t+k+1.
REQ-031 No sample SHALL be accepted between dp_start and the consumption of the corresponding Y, so the buffer is never written mid-evaluation.
REQ-032 flush, when reset=0, SHALL take priority over all other events: next state FILL, fill_cnt<=0, wr_ptr<=0, y_valid<=0, with Y retained.
REQ-033 A sample offered in the flush cycle SHALL NOT be accepted (in_ready forced to 0).
REQ-034 flush during WAIT SHALL abandon the evaluation; the late dp_done SHALL then be ignored per REQ-027.
REQ-035 Only one evaluation SHALL be outstanding at any time.

Reset
REQ-036 While reset=1 at a rising edge: state<=FILL, wr_ptr<=0, fill_cnt<=0, Y<=0, y_valid<=0.
REQ-037 While reset=1: in_ready=0, buf_we=0 and dp_start=0 combinationally.
REQ-038 reset mid-operation (any state, including with y_valid=1) SHALL discard all progress with no output pulse.
REQ-039 reset SHALL take priority over flush.

Verification
REQ-040 Fill: reset for 2 cycles, then in_valid=1 with X=0x10..0x18 -> buf_addr runs 0..8, fill_cnt runs 1..9, dp_start pulses exactly once in the cycle after the 0x18 accept, and in_ready=0 from that cycle on.
REQ-041 Result path: dp_done with dp_result=0x2A3 two cycles after dp_start and y_ready=1 -> Y=0x2A3, y_valid high for 1 cycle, then in_ready=1 in SLIDE.
REQ-042 Slide and wrap: 3 further samples 0x20,0x21,0x22 -> written at buf_addr 0,1,2, one dp_start per sample, fill_cnt stays 9.
REQ-043 Backpressure: y_ready=0 for 5 cycles after dp_done -> Y and y_valid stay stable and in_ready=0; on y_ready=1, y_valid drops at the next edge.
REQ-044 Flush in WAIT, then dp_done -> y_valid stays 0, fill_cnt=0, the next accept goes to buf_addr 0, and 9 accepts are needed before the next dp_start.
REQ-045 Reset asserted in HOLD with y_valid=1 -> after the edge y_valid=0, Y=0 and fill_cnt=0; a spurious dp_done pulse in FILL produces no y_valid.
